map_port_arbiter: RTL and testbench
===================================

# map_port_arbiter

Round-robin arbiter and read sequencer that shares the single read port of the tile collision map among up to NUM_REQ requesters: the player's next-position check, enemy movers and the renderer. Each requester presents a tile coordinate (5-bit X, 5-bit Y, i.e. pixel/32, as produced from the 17-bit fixed-point position bits [16:12]). The block grants one request per cycle, drives the map memory and returns the tile value to the originating requester after a fixed latency. It sits between the movement/draw logic and the map ROM/BRAM.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 4, tile value width; value 0 = free, nonzero = wall
- RD_LAT, 2, map memory read latency in cycles (1..4)
- MAP_W, 20, map width in tiles (used only with bounds check)
- MAP_H, 15, map height in tiles (used only with bounds check)

- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request
- req_x  in  NUM_REQ*5  tile X per requester, slice i = [5i+4:5i]
- req_y  in  NUM_REQ*5  tile Y per requester, same slicing
- req_ready  out  NUM_REQ  one-hot grant; handshake when req_valid[i] & req_ready[i]
- mem_en  out  1  memory read enable
- mem_addr  out  10  {y[4:0], x[4:0]}
- mem_rdata  in  DATA_W  memory data, valid RD_LAT cycles after mem_en
- rsp_valid  out  NUM_REQ  one-hot response strobe, one cycle
- rsp_data  out  DATA_W  tile value for the strobed requester
- rsp_wall  out  1  rsp_data != 0, qualified by |rsp_valid
- busy  out  1  any read in flight

## Operation
- Winner: first i with req_valid[i] set, scanning from rr_ptr upward and wrapping. req_ready is combinational from req_valid and rr_ptr; it is one-hot or zero.
- mem_en = |req_valid. mem_addr = the winner's {y, x}, combinational. A grant occurs in every cycle with any valid request; throughput is 1 read per cycle.
- On a grant to i: rr_ptr <= (i+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Requesters hold req_valid, req_x and req_y stable until they are granted. The block does not require this; a dropped request is simply not served.
- Tag pipeline: RD_LAT stages, each holding {valid, one-hot tag}, shifting every cycle. Stage 0 loads the grant vector.
- At the last stage: rsp_valid = tag, and rsp_data = mem_rdata in the same cycle (no extra register). rsp_data = 0 when no response.
- busy = OR of all pipeline valid bits.
- The same requester may be granted on consecutive cycles; responses return in grant order.
- Asynchronous reset (Reset_n low) clears all pipeline stages and sets rr_ptr to 0. All outputs go low immediately: rsp_valid=0, rsp_data=0, rsp_wall=0, busy=0. req_ready, mem_en and mem_addr are combinational and become 0 only while req_valid=0. In-flight reads are discarded; no late rsp_valid follows reset release.

## Timing
- Grant cycle T: req_ready[i]=1, mem_en=1, mem_addr valid.
- Response at cycle T+RD_LAT: rsp_valid[i]=1 for exactly one cycle.
- With a single requester continuously valid, ready is high every cycle and responses stream every cycle after the initial RD_LAT fill.
- Worst-case wait for any continuously-valid requester: NUM_REQ-1 cycles.

## Configuration
- MAP_BOUNDS_CHECK_EN defined:
  - A granted request with x >= MAP_W or y >= MAP_H is accepted normally, but mem_en is 0 for that cycle.
  - The pipeline carries an out-of-bounds flag with the tag. At T+RD_LAT: rsp_data = all-ones and rsp_wall = 1, with mem_rdata ignored.
  - Off-map positions therefore read as walls.
- MAP_BOUNDS_CHECK_EN undefined: no flag and no compare. The address passes raw (wraps inside 32x32), and mem_en = |req_valid.

## Test plan
- Reset: hold Reset_n=0 with req_valid=4'b1111 for 3 cycles -> rsp_valid=0, busy=0. After release, first grant req_ready=4'b0001, then rr_ptr=1.
- Single request: req_valid[2]=1, x=5, y=3, RD_LAT=2, memory returns 4'h0 -> mem_addr=10'h065 at T; at T+2 rsp_valid=4'b0100, rsp_data=0, rsp_wall=0.
- Fairness: all four valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3. Responses in the same order, each 2 cycles later. Wall tile 4'h1 -> rsp_wall=1.
- Back-to-back: requester 0 alone valid for 5 cycles with addresses 0..4 -> 5 grants, then 5 consecutive rsp_valid=4'b0001 carrying the matching data.
- Reset mid-flight: grant at T, Reset_n low at T+1 -> no rsp_valid at T+2 or after release.
- Bounds (MAP_BOUNDS_CHECK_EN): x=20, y=0 -> mem_en=0 at grant; at T+2 rsp_data=4'hF, rsp_wall=1. Without the macro -> mem_addr=10'h014 with mem_en=1.

Source files
------------

// File: rtl/map_port_arbiter.sv
// map_port_arbiter: round-robin arbiter and read sequencer that shares the
// single read port of the tile collision map among NUM_REQ requesters.
// One grant per cycle. The one-hot tag of each grant travels down an
// RD_LAT-deep pipeline, so the tile value goes back to the requester that
// issued the read.
// Optional feature: define MAP_BOUNDS_CHECK_EN to make off-map coordinates
// (x >= MAP_W or y >= MAP_H) skip the memory read and return as walls.
module map_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4,
  parameter int RD_LAT  = 2,
  parameter int MAP_W   = 20,
  parameter int MAP_H   = 15
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*5-1:0] req_x,
  input  logic [NUM_REQ*5-1:0] req_y,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 mem_en,
  output logic [9:0]           mem_addr,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [DATA_W-1:0]    rsp_data,
  output logic                 rsp_wall,
  output logic                 busy
);
  localparam int PTR_W = $clog2(NUM_REQ);

  // A configuration outside the supported ranges stops elaboration.
  if (NUM_REQ < 2 || NUM_REQ > 8 || RD_LAT < 1 || RD_LAT > 4 ||
      MAP_W < 1 || MAP_W > 32 || MAP_H < 1 || MAP_H > 32) begin : g_bad_cfg
    $error("map_port_arbiter: parameter out of range");
  end

  logic [PTR_W-1:0]                rr_ptr, nxt_ptr, win;
  logic                            any;
  logic [4:0]                      win_x, win_y;
  logic [RD_LAT:1]                 vld_pipe;
  logic [RD_LAT:1][NUM_REQ-1:0]    tag_pipe;

  assign any = |req_valid;

  // Winner scan: first valid requester at or after rr_ptr, with wrap-around.
  always_comb begin
    int   idx;
    logic found;
    req_ready = '0;
    win       = '0;
    nxt_ptr   = rr_ptr;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found          = 1'b1;
        req_ready[idx] = 1'b1;
        win            = PTR_W'(idx);
        nxt_ptr        = (idx + 1 == NUM_REQ) ? '0 : PTR_W'(idx + 1);
      end
    end
  end

  assign win_x    = req_x[int'(win)*5 +: 5];
  assign win_y    = req_y[int'(win)*5 +: 5];
  // The address reads as zero when nothing is requested.
  assign mem_addr = any ? {win_y, win_x} : 10'd0;

`ifdef MAP_BOUNDS_CHECK_EN
  logic                 oob;
  logic [RD_LAT:1]      oob_pipe;

  // An off-map winner is still granted, but the memory read is suppressed.
  assign oob    = ({1'b0, win_x} >= 6'(MAP_W)) || ({1'b0, win_y} >= 6'(MAP_H));
  assign mem_en = any & ~oob;

  // The out-of-bounds flag travels alongside the tag.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      oob_pipe <= '0;
    end else begin
      oob_pipe[1] <= any & oob;
      for (int s = 2; s <= RD_LAT; s++) oob_pipe[s] <= oob_pipe[s-1];
    end
  end

  // Off-map reads return all-ones, so they always look like a wall.
  always_comb begin
    rsp_data = '0;
    if (vld_pipe[RD_LAT]) rsp_data = oob_pipe[RD_LAT] ? '1 : mem_rdata;
  end
`else
  assign mem_en = any;

  // The memory data goes straight to the output in the response cycle.
  always_comb begin
    rsp_data = '0;
    if (vld_pipe[RD_LAT]) rsp_data = mem_rdata;
  end
`endif

  // The round-robin pointer moves past the winner only when a grant occurs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)  rr_ptr <= '0;
    else if (any)  rr_ptr <= nxt_ptr;
  end

  // Tag pipeline. Stage s holds the grant made s cycles ago. Reset drops
  // every read in flight.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe[1] <= any;
      tag_pipe[1] <= req_ready;
      for (int s = 2; s <= RD_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        tag_pipe[s] <= tag_pipe[s-1];
      end
    end
  end

  assign rsp_valid = vld_pipe[RD_LAT] ? tag_pipe[RD_LAT] : '0;
  assign rsp_wall  = |rsp_data;
  assign busy      = |vld_pipe;

endmodule

// File: tb/tb_map_port_arbiter.sv
// tb_map_port_arbiter: scoreboard bench for map_port_arbiter (4 requesters,
// RD_LAT=2). A behavioural memory supplies tile values. For each grant the
// expected response is queued with its due cycle.
module tb_map_port_arbiter;
  localparam int NR = 4, DW = 4, LAT = 2;

  logic           Clk, Reset_n;
  logic [NR-1:0]  req_valid, req_ready, rsp_valid;
  logic [NR*5-1:0] req_x, req_y;
  logic           mem_en, rsp_wall, busy;
  logic [9:0]     mem_addr;
  logic [DW-1:0]  mem_rdata, rsp_data;

  map_port_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .RD_LAT(LAT), .MAP_W(20), .MAP_H(15)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_ready(req_ready), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_wall(rsp_wall), .busy(busy));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int          due;
    logic [NR-1:0] tag;
    logic [DW-1:0] data;
  } exp_t;

  exp_t     sb[$];
  int       n_tests = 0, n_fail = 0, cyc = 0;
  int       rr_m = 0;
  logic [3:0] m1 = 4'h0, m2 = 4'h0;

  function automatic logic [3:0] tile(input logic [9:0] a);
    return a[3:0] ^ 4'h5;
  endfunction

  // Two-cycle memory. Reads without mem_en return filler data.
  always @(posedge Clk) begin
    m1 <= mem_en ? tile(mem_addr) : 4'hA;
    m2 <= m1;
  end
  assign mem_rdata = m2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: drive, check mid-cycle, advance the model at the edge.
  task automatic cycle(input logic [NR-1:0] v, input logic [NR*5-1:0] xs, input logic [NR*5-1:0] ys);
    logic [NR-1:0] g;
    int            w, idx;
    logic          found, oob;
    logic [4:0]    xw, yw;
    req_valid = v; req_x = xs; req_y = ys;
    #4;
    g = '0; w = 0; found = 1'b0;
    for (int k = 0; k < NR; k++) begin
      idx = (rr_m + k) % NR;
      if (!found && v[idx]) begin found = 1'b1; g[idx] = 1'b1; w = idx; end
    end
    xw = xs[w*5 +: 5];
    yw = ys[w*5 +: 5];
`ifdef MAP_BOUNDS_CHECK_EN
    oob = (xw >= 5'd20) || (yw >= 5'd15);
`else
    oob = 1'b0;
`endif
    chk("req_ready", 32'(req_ready), 32'(g));
    chk("mem_en", 32'(mem_en), 32'(found && !oob));
    chk("mem_addr", 32'(mem_addr), found ? 32'({yw, xw}) : 32'd0);
    chk("busy", 32'(busy), 32'(sb.size() != 0));
    if (sb.size() != 0 && sb[0].due == cyc) begin
      chk("rsp_valid", 32'(rsp_valid), 32'(sb[0].tag));
      chk("rsp_data", 32'(rsp_data), 32'(sb[0].data));
      chk("rsp_wall", 32'(rsp_wall), 32'(sb[0].data != 0));
      void'(sb.pop_front());
    end else begin
      chk("rsp_idle_valid", 32'(rsp_valid), 32'd0);
      chk("rsp_idle_data", 32'(rsp_data), 32'd0);
    end
    @(posedge Clk);
    if (Reset_n && found) begin
      sb.push_back('{due: cyc + LAT, tag: g, data: oob ? 4'hF : tile({yw, xw})});
      rr_m = (w + 1) % NR;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, '0, '0);
  endtask

  initial begin
    logic [NR*5-1:0] xs, ys;
    Reset_n = 1'b0;
    for (int i = 0; i < NR; i++) begin
      xs[i*5 +: 5] = 5'(i + 1);
      ys[i*5 +: 5] = 5'(2 * i);
    end
    // All requesters valid while reset is held.
    #6;
    cycle(4'b1111, xs, ys);
    cycle(4'b1111, xs, ys);
    cycle(4'b1111, xs, ys);
    Reset_n = 1'b1;
    // Fairness: eight grants rotate 0,1,2,3,0,1,2,3.
    for (int i = 0; i < 8; i++) cycle(4'b1111, xs, ys);
    idle(3);
    // Single request from requester 2 at (5,3), which reads a free tile.
    xs = '0; ys = '0;
    xs[10 +: 5] = 5'd5; ys[10 +: 5] = 5'd3;
    cycle(4'b0100, xs, ys);
    idle(3);
    // Back-to-back reads from requester 0 at addresses 0..4.
    for (int a = 0; a < 5; a++) begin
      xs = '0; ys = '0;
      xs[4:0] = 5'(a);
      cycle(4'b0001, xs, ys);
    end
    idle(3);
    // Reset arrives while a read is in flight. The read must never complete.
    xs = '0; ys = '0; xs[4:0] = 5'd7; ys[4:0] = 5'd2;
    cycle(4'b0001, xs, ys);
    Reset_n = 1'b0;
    sb.delete();
    rr_m = 0;
    idle(2);
    Reset_n = 1'b1;
    idle(3);
    // Off-map X coordinate.
    xs = '0; ys = '0; xs[4:0] = 5'd20;
    cycle(4'b0001, xs, ys);
    idle(3);
    // Random request mixes.
    for (int i = 0; i < 40; i++) cycle(4'($urandom), 20'($urandom), 20'($urandom));
    idle(4);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
